audio_in: RTL and testbench

//  I2S receiver for the codec ADC path; the capture-side counterpart of the DACDAT serializer.
//  - Oversamples codec BCLK, LRCLK and ADCDAT on the single system clock CLK.
//  - Deserializes left and right words MSB-first.
//  - Presents a stereo sample pair with a one-cycle valid strobe to the distortion DSP chain.
//  - Codec is clock master; this block only observes BCLK and LRCLK.

---
 rtl/audio_in.sv | 202 ++++++++++++++++++++
 tb/tb_audio_in.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/audio_in.sv
// I2S capture deserializer: syncs BCLK/LRCLK/ADCDAT onto CLK, emits stereo pairs.
// Ports: CLK, RESET_N, BCLK, LRCLK, ADCDAT in; left, right, sample_valid, frame_err out.
module audio_in #(
  parameter int DATA_WIDTH = 16,
  parameter int I2S_DELAY  = 1
) (
  input  logic                         CLK,
  input  logic                         RESET_N,
  input  logic                         BCLK,
  input  logic                         LRCLK,
  input  logic                         ADCDAT,
  output logic signed [DATA_WIDTH-1:0] left,
  output logic signed [DATA_WIDTH-1:0] right,
  output logic                         sample_valid,
  output logic                         frame_err
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SKIP,
    SHIFT,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [2:0] bclk_q;
  logic [1:0] lr_q;
  logic [1:0] dat_q;
  logic       lr_last_q;
  logic       lr_seen_q;

  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ch_q, ch_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  ok_q, ok_d;
  logic [DATA_WIDTH-1:0] rword_q, rword_d;
  logic                  pend_q, pend_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] left_q, left_d;
  logic [DATA_WIDTH-1:0] right_q, right_d;
  logic                  valid_q, valid_d;

  logic bclk_rise;
  logic lr_s;
  logic dat_s;
  logic lr_edge;

  assign bclk_rise = bclk_q[1] & ~bclk_q[2];
  assign lr_s      = lr_q[1];
  assign dat_s     = dat_q[1];
  // LRCLK is compared against its value at the previous BCLK rise,
  // so an edge is only seen together with a BCLK rising edge.
  assign lr_edge   = bclk_rise & lr_seen_q & (lr_s != lr_last_q);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      bclk_q    <= '0;
      lr_q      <= '0;
      dat_q     <= '0;
      lr_last_q <= 1'b0;
      lr_seen_q <= 1'b0;
    end else begin
      bclk_q <= {bclk_q[1:0], BCLK};
      lr_q   <= {lr_q[0], LRCLK};
      dat_q  <= {dat_q[0], ADCDAT};
      if (bclk_rise) begin
        lr_last_q <= lr_s;
        lr_seen_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      ch_q    <= 1'b0;
      hold_q  <= '0;
      ok_q    <= 1'b0;
      rword_q <= '0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      left_q  <= '0;
      right_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      hold_q  <= hold_d;
      ok_q    <= ok_d;
      rword_q <= rword_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      left_q  <= left_d;
      right_q <= right_d;
      valid_q <= valid_d;
    end
  end

  logic [DATA_WIDTH-1:0] word;
  logic                  last;
  logic                  start;
  logic                  complete;

  assign word = {shift_q[DATA_WIDTH-2:0], dat_s};
  assign last = (cnt_q == CW'(DATA_WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    ch_d     = ch_q;
    hold_d   = hold_q;
    ok_d     = ok_q;
    rword_d  = rword_q;
    pend_d   = 1'b0;
    err_d    = 1'b0;
    left_d   = left_q;
    right_d  = right_q;
    valid_d  = 1'b0;
    start    = 1'b0;
    complete = 1'b0;

    if (pend_q) begin
      left_d  = hold_q;
      right_d = rword_q;
      valid_d = 1'b1;
    end

    if (bclk_rise) begin
      unique case (state_q)
        IDLE: start = lr_edge;
        SKIP: begin
          if (lr_edge) begin
            start = 1'b1;
          end else begin
            shift_d = {{(DATA_WIDTH-1){1'b0}}, dat_s};
            cnt_d   = CW'(1);
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (last) begin
            complete = 1'b1;
            shift_d  = word;
            state_d  = DONE;
            start    = lr_edge;
          end else if (lr_edge) begin
            err_d = 1'b1;
            ok_d  = 1'b0;
            start = 1'b1;
          end else begin
            shift_d = word;
            cnt_d   = cnt_q + CW'(1);
          end
        end
        DONE: start = lr_edge;
        default: state_d = IDLE;
      endcase
    end

    if (complete) begin
      if (ch_q) begin
        hold_d = word;
        ok_d   = 1'b1;
      end else begin
        ok_d = 1'b0;
        if (ok_q) begin
          rword_d = word;
          pend_d  = 1'b1;
        end
      end
    end

    // A new half-frame; the coinciding BCLK bit is either the
    // delay slot or the MSB of the new word.
    if (start) begin
      ch_d = lr_s;
      if (I2S_DELAY != 0) begin
        state_d = SKIP;
        cnt_d   = '0;
      end else begin
        state_d = SHIFT;
        shift_d = {{(DATA_WIDTH-1){1'b0}}, dat_s};
        cnt_d   = CW'(1);
      end
    end
  end

  assign left         = left_q;
  assign right        = right_q;
  assign sample_valid = valid_q;
  assign frame_err    = err_q;

endmodule

// File: tb/tb_audio_in.sv
// Directed bench for audio_in: I2S/left-justified frames, short frames,
// reset mid-frame and a random run at CLK=4x BCLK.
module tb_audio_in;

  logic CLK;
  logic RESET_N;
  logic BCLK;
  logic LRCLK;
  logic ADCDAT;

  logic signed [15:0] l1, r1, l0, r0;
  logic sv1, fe1, sv0, fe0;

  audio_in #(.DATA_WIDTH(16), .I2S_DELAY(1)) dut1 (
    .CLK(CLK), .RESET_N(RESET_N), .BCLK(BCLK),
    .LRCLK(LRCLK), .ADCDAT(ADCDAT),
    .left(l1), .right(r1),
    .sample_valid(sv1), .frame_err(fe1)
  );

  audio_in #(.DATA_WIDTH(16), .I2S_DELAY(0)) dut0 (
    .CLK(CLK), .RESET_N(RESET_N), .BCLK(BCLK),
    .LRCLK(LRCLK), .ADCDAT(ADCDAT),
    .left(l0), .right(r0),
    .sample_valid(sv0), .frame_err(fe0)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;
  int H = 4;

  int n1 = 0, e1 = 0, n0 = 0, e0 = 0;
  logic signed [15:0] ml1 = '0, mr1 = '0, ml0 = '0, mr0 = '0;

  always @(negedge CLK) begin
    if (sv1) begin
      n1  <= n1 + 1;
      ml1 <= l1;
      mr1 <= r1;
    end
    if (fe1) e1 <= e1 + 1;
    if (sv0) begin
      n0  <= n0 + 1;
      ml0 <= l0;
      mr0 <= r0;
    end
    if (fe0) e0 <= e0 + 1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic slot(input logic lr, input logic d);
    BCLK = 1'b0;
    LRCLK = lr;
    ADCDAT = d;
    repeat (H) @(negedge CLK);
    BCLK = 1'b1;
    repeat (H) @(negedge CLK);
  endtask

  task automatic half(input logic lr, input logic [15:0] w,
                      input int n, input int d);
    for (int k = 0; k < n; k++) begin
      int idx;
      logic b;
      idx = 15 - (k - d);
      b = (idx >= 0 && idx < 16 && k >= d) ? w[idx[3:0]] : 1'b0;
      slot(lr, b);
    end
  endtask

  task automatic frame(input logic [15:0] lw, input logic [15:0] rw,
                       input int n, input int d);
    half(1'b1, lw, n, d);
    half(1'b0, rw, n, d);
  endtask

  task automatic settle();
    repeat (8) @(negedge CLK);
    #1;
  endtask

  initial begin
    int b, eb, b0, eb0;
    logic [15:0] lw, rw;

    RESET_N = 1'b0;
    BCLK = 1'b0;
    LRCLK = 1'b0;
    ADCDAT = 1'b0;
    repeat (4) @(negedge CLK);
    #1;
    chk("rst_left", int'(l1), 0);
    chk("rst_right", int'(r1), 0);
    chk("rst_valid", int'(sv1), 0);
    chk("rst_err", int'(fe1), 0);
    RESET_N = 1'b1;

    // start on a right half: that word must be dropped
    H = 4;
    for (int i = 0; i < 4; i++) slot(1'b1, 1'b0);
    half(1'b0, 16'h1234, 32, 1);
    settle();
    chk("midr_nostrobe", n1, 0);
    frame(16'hABCD, 16'h5678, 32, 1);
    settle();
    chk("midr_count", n1, 1);
    chk("midr_left", int'(ml1), int'($signed(16'hABCD)));
    chk("midr_right", int'(mr1), int'($signed(16'h5678)));
    chk("midr_err", e1, 0);

    b = n1;
    frame(16'h8001, 16'h7FFE, 32, 1);
    frame(16'h8001, 16'h7FFE, 32, 1);
    settle();
    chk("nom_count", n1, b + 2);
    chk("nom_left", int'(ml1), -32767);
    chk("nom_right", int'(mr1), 32766);
    chk("nom_err", e1, 0);

    b = n1;
    eb = e1;
    half(1'b1, 16'hAAAA, 10, 1);
    half(1'b0, 16'h5555, 32, 1);
    settle();
    chk("short_err", e1, eb + 1);
    chk("short_nostrobe", n1, b);
    frame(16'h1111, 16'h2222, 32, 1);
    settle();
    chk("short_next_count", n1, b + 1);
    chk("short_next_left", int'(ml1), 32'h1111);
    chk("short_next_right", int'(mr1), 32'h2222);
    chk("short_err_once", e1, eb + 1);

    half(1'b1, 16'h3333, 32, 1);
    half(1'b0, 16'h4444, 8, 1);
    RESET_N = 1'b0;
    #1;
    chk("midrst_left", int'(l1), 0);
    chk("midrst_right", int'(r1), 0);
    chk("midrst_valid", int'(sv1), 0);
    chk("midrst_err", int'(fe1), 0);
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;
    b = n1;
    for (int i = 0; i < 24; i++) slot(1'b0, 1'b1);
    settle();
    chk("postrst_nostrobe", n1, b);
    frame(16'h5555, 16'h6666, 32, 1);
    settle();
    chk("postrst_count", n1, b + 1);
    chk("postrst_left", int'(ml1), 32'h5555);
    chk("postrst_right", int'(mr1), 32'h6666);

    H = 2;
    for (int f = 0; f < 100; f++) begin
      lw = 16'($urandom);
      rw = 16'($urandom);
      b = n1;
      frame(lw, rw, 32, 1);
      settle();
      chk("rnd_count", n1, b + 1);
      chk("rnd_pair", int'({ml1, mr1}), int'({lw, rw}));
    end

    H = 4;
    b0 = n0;
    eb0 = e0;
    for (int f = 0; f < 3; f++) frame(16'hFFFF, 16'h0000, 16, 0);
    settle();
    chk("lj_count", n0, b0 + 3);
    chk("lj_left", int'(ml0), -1);
    chk("lj_right", int'(mr0), 0);
    chk("lj_err", e0, eb0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
